byte_serial_adder: RTL and testbench
====================================

# byte_serial_adder

Multi-byte adder/subtractor that walks two NBYTES-wide operands through one shared 8-bit carry-lookahead adder datapath, one byte per clock, least-significant byte first. It is the sequencing stage directly upstream of the 8-bit CLA: it slices operands into bytes, feeds the adder, registers the carry between bytes, and captures the per-byte sums. The result is a wide add/sub at 8-bit adder cost, with a start/busy/done handshake toward the controlling logic.

## Interface
- NBYTES, default 4: operand width in bytes, legal range 1..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B+cin, 1 = A−B (cin ignored); latched at start.
- a  input  8*NBYTES  operand A; latched at start.
- b  input  8*NBYTES  operand B; latched at start.
- cin  input  1  carry-in for add; latched at start.
- busy  output  1  high while bytes are being processed (RUN).
- done  output  1  one-cycle pulse; sum/cout/ovf valid.
- sum  output  8*NBYTES  result register.
- cout  output  1  carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow of the full-width result.

## Operation
- Reset: state IDLE. Byte index, carry register, operand registers, sum, cout, ovf, busy and done are all 0.
- IDLE: when start=1 at a clock edge:
  - latch a and b, with b bitwise inverted when sub=1.
  - load the carry register with sub ? 1 : cin.
  - set index 0 and go to RUN.
  - start=0 means stay in IDLE.
- RUN, every edge:
  - byte idx of A, plus byte idx of the effective B, plus the carry register, goes through the 8-bit adder.
  - the 8-bit sum is written into byte idx of the working result.
  - the adder carry-out is written into the carry register.
  - idx increments.
- RUN exit: on the edge that processes byte NBYTES−1:
  - transfer the working result to sum.
  - cout = final carry.
  - ovf = (a_msb == beff_msb) && (sum_msb != a_msb), where beff is the inverted B in sub mode.
  - go to DONE.
- DONE: lasts one cycle with done=1, then returns to IDLE.
- sum, cout and ovf hold their values until the next completion or reset. They are never modified during RUN; partial bytes go to a separate working register.
- start is ignored in RUN and DONE. No queuing. The operand and sub inputs may change freely after the start edge.
- Width rules: all byte arithmetic is modulo 2^8. The carry chain spans the full 8*NBYTES bits. The result is modulo 2^(8*NBYTES).
- NBYTES=1: RUN lasts exactly one edge. The block is then equivalent to a registered 8-bit add.
- Reset mid-operation, asynchronous, any state:
  - immediately return to IDLE with all outputs 0.
  - no done pulse.
  - the aborted result is discarded.

## Timing
- Start edge E0 (start=1, IDLE) means busy=1 from just after E0.
- Bytes 0..NBYTES−1 are processed on edges E1..E_NBYTES.
- After E_NBYTES: busy=0, done=1, and sum/cout/ovf are updated.
- After E_NBYTES+1: done=0 and the state is IDLE.
- The earliest accepted new start is at E_NBYTES+2. The issue interval is NBYTES+2 cycles.
- Latency from start edge to done high is NBYTES cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- The critical path is one 8-bit CLA plus the operand and carry muxing.

## Test plan
All scenarios use NBYTES=4.
- Add with inter-byte carry: a=0x000000FF, b=0x00000001, cin=0, sub=0 -> done 4 cycles after start; sum=0x00000100, cout=0, ovf=0.
- Full-width carry-out and cin: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0. Separately, a=0xFFFFFFFF, b=0xFFFFFFFF, cin=0 -> sum=0xFFFFFFFE, cout=1.
- Subtract with borrow: sub=1, a=0x00000005, b=0x00000007, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Separately, sub=1, a=0x00000007, b=0x00000005 -> sum=0x00000002, cout=1.
- Signed overflow: a=0x7FFFFFFF + b=0x00000001 -> sum=0x80000000, ovf=1, cout=0. Separately, sub=1, a=0x80000000, b=0x00000001 -> sum=0x7FFFFFFF, ovf=1.
- Handshake: hold start=1 continuously with changing a/b.
  - Required: exactly one done pulse per NBYTES+2 cycles.
  - Required: each result matches the operands present at its own accepting edge.
  - Required: busy never overlaps done.
- Reset mid-op: assert rst_n=0 two cycles into RUN -> busy, done, sum, cout and ovf are 0 immediately (before the next edge). After release, no done appears without a new start. A fresh a=0x12345678 + b=0x11111111 gives sum=0x23456789.

Source files
------------

// File: rtl/byte_serial_adder.sv
// Byte-serial multi-byte adder/subtractor: walks two NBYTES-wide operands
// through a single 8-bit carry-lookahead adder, least-significant byte first.
module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                ovf
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // 8-bit carry-lookahead add; returns {carry_out, sum[7:0]}
  function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y,
                                      input logic c0);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    for (int i = 0; i < 8; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return {c[8], p ^ c[7:0]};
  endfunction

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_op;
  logic [W-1:0]     b_op;
  logic [W-1:0]     work;
  logic [W-1:0]     work_next;
  logic [8:0]       add_res;

  always_comb begin
    add_res   = cla8(a_op[idx*8 +: 8], b_op[idx*8 +: 8], carry);
    work_next = work;
    work_next[idx*8 +: 8] = add_res[7:0];
  end

  // b_op already holds the inverted operand in subtract mode, so one
  // overflow rule covers both add and subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_op  <= '0;
      b_op  <= '0;
      work  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_op  <= a;
            b_op  <= sub ? ~b : b;
            carry <= sub | cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          work  <= work_next;
          carry <= add_res[8];
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            sum   <= work_next;
            cout  <= add_res[8];
            ovf   <= (a_op[W-1] == b_op[W-1]) && (work_next[W-1] != a_op[W-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Randomized self-checking bench for byte_serial_adder (NBYTES=4) against an
// arithmetic reference model.
module tb_byte_serial_adder;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
  localparam int PERIOD = NBYTES + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int failures = 0;

  byte_serial_adder #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on the full width
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input logic ci, input logic s,
                                output logic [31:0] sm, output logic co, output logic ov);
    longint ux, uy, sx, sy, r, sr;
    ux = x;
    uy = y;
    sx = $signed(x);
    sy = $signed(y);
    if (!s) begin
      r  = ux + uy + ci;
      sr = sx + sy + ci;
      co = (r >= 64'h1_0000_0000);
    end else begin
      r  = ux - uy;
      sr = sx - sy;
      co = (ux >= uy);
    end
    sm = r[31:0];
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic s);
    logic [31:0] esum;
    logic        eco, eov;
    logic [31:0] prev;
    model(x, y, ci, s, esum, eco, eov);
    @(negedge clk);
    a = x; b = y; cin = ci; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    prev  = sum;
    start = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    chk({tag, "_busy0"}, 64'(busy), 64'd1);
    for (int k = 1; k <= NBYTES; k++) begin
      @(posedge clk);
      #1;
      if (k < NBYTES) begin
        chk({tag, "_run_done"}, 64'(done), 64'd0);
        chk({tag, "_run_sum_hold"}, 64'(sum), 64'(prev));
      end else begin
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_sum"}, 64'(sum), 64'(esum));
        chk({tag, "_cout"}, 64'(cout), 64'(eco));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eov));
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_done_fall"}, 64'(done), 64'd0);
  endtask

  logic [31:0] da [10] = '{32'h000000FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000005, 32'h00000007,
                           32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000, 32'h12345678};
  logic [31:0] db [10] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 32'h00000005,
                           32'h00000001, 32'h00000001, 32'h80000000, 32'h80000000, 32'h11111111};
  logic        dc [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        ds [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ha, hb, esum;
    logic        hc, hs, eco, eov;

    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op($sformatf("dir%0d", i), da[i], db[i], dc[i], ds[i]);
    for (int i = 0; i < 12; i++)
      run_op($sformatf("rnd%0d", i), $urandom, $urandom, 1'($urandom), 1'($urandom));

    // start held high: DUT is idle, so the first edge is an accepting edge
    ha = '0; hb = '0; hc = 1'b0; hs = 1'b0;
    for (int n = 0; n < 4 * PERIOD; n++) begin
      @(negedge clk);
      start = 1'b1;
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      if (n % PERIOD == 0) begin
        ha = a; hb = b; hc = cin; hs = sub;
      end
      @(posedge clk);
      #1;
      chk("hs_done", 64'(done), 64'(n % PERIOD == NBYTES));
      chk("hs_overlap", 64'(busy & done), 64'd0);
      if (n % PERIOD == NBYTES) begin
        model(ha, hb, hc, hs, esum, eco, eov);
        chk("hs_sum", 64'(sum), 64'(esum));
        chk("hs_cout", 64'(cout), 64'(eco));
        chk("hs_ovf", 64'(ovf), 64'(eov));
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (PERIOD) @(posedge clk);

    // reset two cycles into RUN, after a result with nonzero fields is held
    run_op("pre_rst", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01010101; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_sum", 64'(sum), 64'd0);
    chk("mid_rst_cout", 64'(cout), 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < PERIOD + 2; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_nodone", 64'(done), 64'd0);
      chk("post_rst_idle", 64'(busy), 64'd0);
    end
    run_op("fresh", 32'h12345678, 32'h11111111, 1'b0, 1'b0);
    chk("fresh_const", 64'(sum), 64'h23456789);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
